// File: rtl/resource_table_sequencer.sv
// Front-end sequencer for resource_table: buffers alloc/dealloc requests,
// round-robins between them and runs one table operation at a time to completion.
module resource_table_sequencer #(
    parameter int CU_ID_WIDTH        = 1,
    parameter int NUMBER_CU          = 2,
    parameter int WG_SLOT_ID_WIDTH   = 4,
    parameter int RES_ID_WIDTH       = 4,
    parameter int NUMBER_RES_SLOTS   = 16,
    parameter int DEALLOC_FIFO_DEPTH = 4,
    parameter int DEALLOC_PTR_WIDTH  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        alloc_req_valid,
    output logic                        alloc_req_ready,
    input  logic [CU_ID_WIDTH-1:0]      alloc_req_cu_id,
    input  logic [WG_SLOT_ID_WIDTH-1:0] alloc_req_wg_slot_id,
    input  logic [RES_ID_WIDTH-1:0]     alloc_req_res_start,
    input  logic [RES_ID_WIDTH:0]       alloc_req_res_size,
    input  logic                        dealloc_req_valid,
    output logic                        dealloc_req_ready,
    input  logic [CU_ID_WIDTH-1:0]      dealloc_req_cu_id,
    input  logic [WG_SLOT_ID_WIDTH-1:0] dealloc_req_wg_slot_id,
    output logic                        alloc_res_en,
    output logic                        dealloc_res_en,
    output logic [CU_ID_WIDTH-1:0]      alloc_cu_id,
    output logic [WG_SLOT_ID_WIDTH-1:0] alloc_wg_slot_id,
    output logic [RES_ID_WIDTH-1:0]     alloc_res_start,
    output logic [RES_ID_WIDTH:0]       alloc_res_size,
    output logic [CU_ID_WIDTH-1:0]      dealloc_cu_id,
    output logic [WG_SLOT_ID_WIDTH-1:0] dealloc_wg_slot_id,
    input  logic                        res_table_done,
    input  logic [RES_ID_WIDTH:0]       cam_biggest_space_size,
    input  logic [RES_ID_WIDTH-1:0]     cam_biggest_space_addr,
    output logic                        cmpl_valid,
    output logic                        cmpl_is_alloc,
    output logic [CU_ID_WIDTH-1:0]      cmpl_cu_id,
    output logic [WG_SLOT_ID_WIDTH-1:0] cmpl_wg_slot_id,
    output logic [RES_ID_WIDTH:0]       cmpl_space_size,
    output logic [RES_ID_WIDTH-1:0]     cmpl_space_addr,
    output logic                        busy,
    output logic                        err_spurious_done,
    output logic                        err_bad_size
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_CMPL  = 2'd3;

    localparam logic [RES_ID_WIDTH+1:0]    SLOT_LIMIT = (RES_ID_WIDTH+2)'(NUMBER_RES_SLOTS);
    localparam logic [DEALLOC_PTR_WIDTH:0] FIFO_FULL  = (DEALLOC_PTR_WIDTH+1)'(DEALLOC_FIFO_DEPTH);

    if (NUMBER_CU > (1 << CU_ID_WIDTH) || DEALLOC_FIFO_DEPTH != (1 << DEALLOC_PTR_WIDTH)) begin : g_cfg_check
        $error("resource_table_sequencer: inconsistent CU or FIFO sizing parameters");
    end

    logic [1:0]                  state;
    logic                        up;
    logic                        rr_last_alloc;
    logic                        op_is_alloc;

    logic                        a_full;
    logic [CU_ID_WIDTH-1:0]      a_cu;
    logic [WG_SLOT_ID_WIDTH-1:0] a_wg;
    logic [RES_ID_WIDTH-1:0]     a_start;
    logic [RES_ID_WIDTH:0]       a_size;

    logic [CU_ID_WIDTH-1:0]      f_cu [DEALLOC_FIFO_DEPTH];
    logic [WG_SLOT_ID_WIDTH-1:0] f_wg [DEALLOC_FIFO_DEPTH];
    logic [DEALLOC_PTR_WIDTH-1:0] wr_ptr, rd_ptr;
    logic [DEALLOC_PTR_WIDTH:0]   count;

    logic                    alloc_acc, alloc_bad, dealloc_push, dealloc_pop, dealloc_pend;
    logic                    start_op, pick_alloc;
    logic [RES_ID_WIDTH+1:0] res_sum;

    always_comb begin
        alloc_req_ready   = up & ~a_full;
        dealloc_req_ready = up & (count != FIFO_FULL);
        alloc_acc         = alloc_req_valid & alloc_req_ready;
        dealloc_push      = dealloc_req_valid & dealloc_req_ready;
        res_sum           = {2'b00, alloc_req_res_start} + {1'b0, alloc_req_res_size};
        alloc_bad         = (alloc_req_res_size == '0) || (res_sum > SLOT_LIMIT);
        dealloc_pend      = (count != '0);
        // With both pending, the type not served last time wins.
        pick_alloc        = a_full & (~dealloc_pend | ~rr_last_alloc);
        start_op          = (state == ST_IDLE) & (a_full | dealloc_pend);
        dealloc_pop       = start_op & ~pick_alloc;
        alloc_res_en      = (state == ST_ISSUE) & op_is_alloc;
        dealloc_res_en    = (state == ST_ISSUE) & ~op_is_alloc;
        cmpl_valid        = (state == ST_CMPL);
        busy              = (state != ST_IDLE) | a_full | dealloc_pend;
    end

    always_ff @(posedge clk) begin
        if (dealloc_push) begin
            f_cu[wr_ptr] <= dealloc_req_cu_id;
            f_wg[wr_ptr] <= dealloc_req_wg_slot_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            up <= 1'b0;
            rr_last_alloc <= 1'b1;
            op_is_alloc <= 1'b0;
            a_full <= 1'b0;
            a_cu <= '0;
            a_wg <= '0;
            a_start <= '0;
            a_size <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            alloc_cu_id <= '0;
            alloc_wg_slot_id <= '0;
            alloc_res_start <= '0;
            alloc_res_size <= '0;
            dealloc_cu_id <= '0;
            dealloc_wg_slot_id <= '0;
            cmpl_is_alloc <= 1'b0;
            cmpl_cu_id <= '0;
            cmpl_wg_slot_id <= '0;
            cmpl_space_size <= '0;
            cmpl_space_addr <= '0;
            err_spurious_done <= 1'b0;
            err_bad_size <= 1'b0;
        end else begin
            up <= 1'b1;
            if (alloc_acc && alloc_bad) err_bad_size <= 1'b1;
            if (res_table_done && state != ST_WAIT) err_spurious_done <= 1'b1;

            if (start_op && pick_alloc) begin
                a_full <= 1'b0;
            end else if (alloc_acc && !alloc_bad) begin
                a_full <= 1'b1;
                a_cu <= alloc_req_cu_id;
                a_wg <= alloc_req_wg_slot_id;
                a_start <= alloc_req_res_start;
                a_size <= alloc_req_res_size;
            end

            if (dealloc_push) wr_ptr <= wr_ptr + DEALLOC_PTR_WIDTH'(1);
            if (dealloc_pop) rd_ptr <= rd_ptr + DEALLOC_PTR_WIDTH'(1);
            if (dealloc_push && !dealloc_pop) count <= count + (DEALLOC_PTR_WIDTH+1)'(1);
            else if (!dealloc_push && dealloc_pop) count <= count - (DEALLOC_PTR_WIDTH+1)'(1);

            case (state)
                ST_IDLE: begin
                    if (start_op) begin
                        op_is_alloc <= pick_alloc;
                        rr_last_alloc <= pick_alloc;
                        if (pick_alloc) begin
                            alloc_cu_id <= a_cu;
                            alloc_wg_slot_id <= a_wg;
                            alloc_res_start <= a_start;
                            alloc_res_size <= a_size;
                        end else begin
                            dealloc_cu_id <= f_cu[rd_ptr];
                            dealloc_wg_slot_id <= f_wg[rd_ptr];
                        end
                        state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: state <= ST_WAIT;
                ST_WAIT: begin
                    if (res_table_done) begin
                        cmpl_is_alloc <= op_is_alloc;
                        cmpl_cu_id <= op_is_alloc ? alloc_cu_id : dealloc_cu_id;
                        cmpl_wg_slot_id <= op_is_alloc ? alloc_wg_slot_id : dealloc_wg_slot_id;
                        cmpl_space_size <= cam_biggest_space_size;
                        cmpl_space_addr <= cam_biggest_space_addr;
                        state <= ST_CMPL;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_resource_table_sequencer.sv
// Scoreboard bench for resource_table_sequencer: directed requests, a table
// responder that answers each strobe, and a monitor checking strobes and completions.
module tb_resource_table_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       alloc_req_valid, alloc_req_ready;
    logic [0:0] alloc_req_cu_id;
    logic [3:0] alloc_req_wg_slot_id, alloc_req_res_start;
    logic [4:0] alloc_req_res_size;
    logic       dealloc_req_valid, dealloc_req_ready;
    logic [0:0] dealloc_req_cu_id;
    logic [3:0] dealloc_req_wg_slot_id;
    logic       alloc_res_en, dealloc_res_en;
    logic [0:0] alloc_cu_id;
    logic [3:0] alloc_wg_slot_id, alloc_res_start;
    logic [4:0] alloc_res_size;
    logic [0:0] dealloc_cu_id;
    logic [3:0] dealloc_wg_slot_id;
    logic       res_table_done;
    logic [4:0] cam_biggest_space_size;
    logic [3:0] cam_biggest_space_addr;
    logic       cmpl_valid, cmpl_is_alloc;
    logic [0:0] cmpl_cu_id;
    logic [3:0] cmpl_wg_slot_id;
    logic [4:0] cmpl_space_size;
    logic [3:0] cmpl_space_addr;
    logic       busy, err_spurious_done, err_bad_size;

    resource_table_sequencer #(
        .CU_ID_WIDTH(1), .NUMBER_CU(2), .WG_SLOT_ID_WIDTH(4), .RES_ID_WIDTH(4),
        .NUMBER_RES_SLOTS(16), .DEALLOC_FIFO_DEPTH(4), .DEALLOC_PTR_WIDTH(2)
    ) dut (
        .clk(clk), .rst(rst),
        .alloc_req_valid(alloc_req_valid), .alloc_req_ready(alloc_req_ready),
        .alloc_req_cu_id(alloc_req_cu_id), .alloc_req_wg_slot_id(alloc_req_wg_slot_id),
        .alloc_req_res_start(alloc_req_res_start), .alloc_req_res_size(alloc_req_res_size),
        .dealloc_req_valid(dealloc_req_valid), .dealloc_req_ready(dealloc_req_ready),
        .dealloc_req_cu_id(dealloc_req_cu_id), .dealloc_req_wg_slot_id(dealloc_req_wg_slot_id),
        .alloc_res_en(alloc_res_en), .dealloc_res_en(dealloc_res_en),
        .alloc_cu_id(alloc_cu_id), .alloc_wg_slot_id(alloc_wg_slot_id),
        .alloc_res_start(alloc_res_start), .alloc_res_size(alloc_res_size),
        .dealloc_cu_id(dealloc_cu_id), .dealloc_wg_slot_id(dealloc_wg_slot_id),
        .res_table_done(res_table_done),
        .cam_biggest_space_size(cam_biggest_space_size), .cam_biggest_space_addr(cam_biggest_space_addr),
        .cmpl_valid(cmpl_valid), .cmpl_is_alloc(cmpl_is_alloc),
        .cmpl_cu_id(cmpl_cu_id), .cmpl_wg_slot_id(cmpl_wg_slot_id),
        .cmpl_space_size(cmpl_space_size), .cmpl_space_addr(cmpl_space_addr),
        .busy(busy), .err_spurious_done(err_spurious_done), .err_bad_size(err_bad_size)
    );

    typedef struct packed {
        logic       is_alloc;
        logic [0:0] cu;
        logic [3:0] wg;
        logic [3:0] start;
        logic [4:0] size;
    } tab_t;

    typedef struct packed {
        logic       is_alloc;
        logic [0:0] cu;
        logic [3:0] wg;
        logic [4:0] size;
        logic [3:0] addr;
    } cmpl_t;

    tab_t  exp_tab[$];
    cmpl_t exp_cmpl[$];
    int checks = 0;
    int errors = 0;
    logic hold = 1'b0;
    int done_delay = 3;
    int op_count = 0;
    int spur_req = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic any_output();
        return |{alloc_req_ready, dealloc_req_ready, alloc_res_en, dealloc_res_en,
                 alloc_cu_id, alloc_wg_slot_id, alloc_res_start, alloc_res_size,
                 dealloc_cu_id, dealloc_wg_slot_id, cmpl_valid, cmpl_is_alloc,
                 cmpl_cu_id, cmpl_wg_slot_id, cmpl_space_size, cmpl_space_addr,
                 busy, err_spurious_done, err_bad_size};
    endfunction

    // Monitor: every strobe and completion must match the head of its queue.
    always @(negedge clk) begin
        tab_t  at, et;
        cmpl_t ac, ec;
        if (alloc_res_en && dealloc_res_en) check("en_exclusive", 32'({alloc_res_en, dealloc_res_en}), 32'h1);
        if (alloc_res_en || dealloc_res_en) begin
            at = alloc_res_en ? {1'b1, alloc_cu_id, alloc_wg_slot_id, alloc_res_start, alloc_res_size}
                              : {1'b0, dealloc_cu_id, dealloc_wg_slot_id, 4'h0, 5'h0};
            if (exp_tab.size() == 0) begin
                checks++; errors++;
                $display("FAIL table_op unexpected actual=%0h expected=none", at);
            end else begin
                et = exp_tab.pop_front();
                check("table_op", 32'(at), 32'(et));
            end
        end
        if (cmpl_valid) begin
            ac = {cmpl_is_alloc, cmpl_cu_id, cmpl_wg_slot_id, cmpl_space_size, cmpl_space_addr};
            if (exp_cmpl.size() == 0) begin
                checks++; errors++;
                $display("FAIL completion unexpected actual=%0h expected=none", ac);
            end else begin
                ec = exp_cmpl.pop_front();
                check("completion", 32'(ac), 32'(ec));
            end
        end
    end

    // Table responder: answers each strobe after done_delay cycles unless stalled.
    initial begin
        int spur_done;
        int d;
        spur_done = 0;
        res_table_done = 1'b0;
        cam_biggest_space_size = '0;
        cam_biggest_space_addr = '0;
        forever begin
            @(negedge clk);
            if (spur_req != spur_done) begin
                spur_done = spur_req;
                res_table_done = 1'b1;
                @(negedge clk);
                res_table_done = 1'b0;
            end else if (alloc_res_en || dealloc_res_en) begin
                d = 0;
                while ((hold || d < done_delay) && d < 3000) begin
                    @(negedge clk);
                    d++;
                end
                cam_biggest_space_size = 5'(op_count + 3);
                cam_biggest_space_addr = 4'(op_count + 1);
                res_table_done = 1'b1;
                @(negedge clk);
                res_table_done = 1'b0;
                op_count++;
            end
        end
    end

    task automatic send_alloc(input logic [0:0] cu, input logic [3:0] wg, input logic [3:0] st,
                              input logic [4:0] sz);
        int n;
        @(negedge clk);
        alloc_req_valid = 1'b1;
        alloc_req_cu_id = cu;
        alloc_req_wg_slot_id = wg;
        alloc_req_res_start = st;
        alloc_req_res_size = sz;
        n = 0;
        while (!alloc_req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            checks++; errors++;
            $display("FAIL alloc_accept timeout actual=ready_low expected=ready_high");
        end
        @(posedge clk);
        #1 alloc_req_valid = 1'b0;
    endtask

    task automatic send_dealloc(input logic [0:0] cu, input logic [3:0] wg);
        int n;
        @(negedge clk);
        dealloc_req_valid = 1'b1;
        dealloc_req_cu_id = cu;
        dealloc_req_wg_slot_id = wg;
        n = 0;
        while (!dealloc_req_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 1000) begin
            checks++; errors++;
            $display("FAIL dealloc_accept timeout actual=ready_low expected=ready_high");
        end
        @(posedge clk);
        #1 dealloc_req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        repeat (2) @(negedge clk);
        n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            checks++; errors++;
            $display("FAIL drain timeout actual=busy expected=idle");
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        rst = 1'b1;
        alloc_req_valid = 1'b0; alloc_req_cu_id = '0; alloc_req_wg_slot_id = '0;
        alloc_req_res_start = '0; alloc_req_res_size = '0;
        dealloc_req_valid = 1'b0; dealloc_req_cu_id = '0; dealloc_req_wg_slot_id = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'(any_output()), 32'h0);
        rst = 1'b0;
        check("ready_at_release", 32'({alloc_req_ready, dealloc_req_ready}), 32'h0);
        @(negedge clk);
        check("ready_after_release", 32'({alloc_req_ready, dealloc_req_ready}), 32'h3);

        // T1: single alloc
        exp_tab.push_back({1'b1, 1'b0, 4'd0, 4'd0, 5'd5});
        exp_cmpl.push_back({1'b1, 1'b0, 4'd0, 5'd3, 4'd1});
        send_alloc(1'b0, 4'd0, 4'd0, 5'd5);
        wait_idle();

        // T2: simultaneous alloc and dealloc from reset, dealloc wins first
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        exp_tab.push_back({1'b0, 1'b1, 4'd2, 4'd0, 5'd0});
        exp_cmpl.push_back({1'b0, 1'b1, 4'd2, 5'd4, 4'd2});
        exp_tab.push_back({1'b1, 1'b0, 4'd0, 4'd0, 5'd5});
        exp_cmpl.push_back({1'b1, 1'b0, 4'd0, 5'd5, 4'd3});
        alloc_req_valid = 1'b1; alloc_req_cu_id = 1'b0; alloc_req_wg_slot_id = 4'd0;
        alloc_req_res_start = 4'd0; alloc_req_res_size = 5'd5;
        dealloc_req_valid = 1'b1; dealloc_req_cu_id = 1'b1; dealloc_req_wg_slot_id = 4'd2;
        n = 0;
        while (!(alloc_req_ready && dealloc_req_ready) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t2_both_ready", 32'({alloc_req_ready, dealloc_req_ready}), 32'h3);
        @(posedge clk);
        #1 begin alloc_req_valid = 1'b0; dealloc_req_valid = 1'b0; end
        wait_idle();

        // T3: dealloc FIFO fills while the table is stalled
        hold = 1'b1;
        exp_tab.push_back({1'b1, 1'b1, 4'd3, 4'd4, 5'd4});
        exp_cmpl.push_back({1'b1, 1'b1, 4'd3, 5'd6, 4'd4});
        for (int i = 0; i < 5; i++) begin
            exp_tab.push_back({1'b0, 1'(i), 4'(2*i+1), 4'd0, 5'd0});
            exp_cmpl.push_back({1'b0, 1'(i), 4'(2*i+1), 5'(7+i), 4'(5+i)});
        end
        send_alloc(1'b1, 4'd3, 4'd4, 5'd4);
        for (int i = 0; i < 4; i++) send_dealloc(1'(i), 4'(2*i+1));
        @(negedge clk);
        check("t3_full_ready", 32'(dealloc_req_ready), 32'h0);
        dealloc_req_valid = 1'b1; dealloc_req_cu_id = 1'b0; dealloc_req_wg_slot_id = 4'd9;
        repeat (3) @(negedge clk);
        check("t3_full_hold", 32'(dealloc_req_ready), 32'h0);
        hold = 1'b0;
        n = 0;
        while (!dealloc_req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t3_fifth_ready", 32'(dealloc_req_ready), 32'h1);
        @(posedge clk);
        #1 dealloc_req_valid = 1'b0;
        wait_idle();

        // T4: out-of-range alloc dropped, boundary alloc accepted
        check("t4_flag_before", 32'(err_bad_size), 32'h0);
        send_alloc(1'b0, 4'd1, 4'd15, 5'd2);
        repeat (3) @(negedge clk);
        check("t4_bad_flag", 32'(err_bad_size), 32'h1);
        check("t4_bad_not_busy", 32'(busy), 32'h0);
        exp_tab.push_back({1'b1, 1'b0, 4'd1, 4'd15, 5'd1});
        exp_cmpl.push_back({1'b1, 1'b0, 4'd1, 5'd12, 4'd10});
        send_alloc(1'b0, 4'd1, 4'd15, 5'd1);
        wait_idle();

        // T5: spurious done while idle
        check("t5_flag_before", 32'(err_spurious_done), 32'h0);
        spur_req++;
        repeat (4) @(negedge clk);
        check("t5_spurious_flag", 32'(err_spurious_done), 32'h1);
        check("t5_still_idle", 32'(busy), 32'h0);

        // T6: reset while waiting on the table
        hold = 1'b1;
        exp_tab.push_back({1'b1, 1'b1, 4'd6, 4'd2, 5'd3});
        send_alloc(1'b1, 4'd6, 4'd2, 5'd3);
        repeat (4) @(negedge clk);
        check("t6_busy_in_wait", 32'(busy), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_reset_outputs", 32'(any_output()), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        hold = 1'b0;
        repeat (10) @(negedge clk);
        check("t6_idle_after_done", 32'(busy), 32'h0);

        check("tab_queue_empty", 32'(exp_tab.size()), 32'h0);
        check("cmpl_queue_empty", 32'(exp_cmpl.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
